pim_weight_loader: RTL

- Upstream sequencer for the PIM weight buffer. Accepts a command to load N consecutive macro rows, then takes 32-bit weight words from a valid/ready stream (CPU MMIO FIFO or DMA).
- Produces the buffer's write enable, 4-bit beat index and data: 16 beats of {cam[15:0], cim[15:0]} per row.
- After each full row, asserts weight output enable and the macro write strobe with the row address, holds until the macro acks, then advances.

---
 rtl/pim_wload_pkg.sv | 20 ++
 rtl/pim_wload_timer.sv | 26 ++
 rtl/pim_weight_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pim_wload_pkg.sv
// Shared encodings for the PIM weight loader: FSM states, beat defaults and
// the cam/cim split of a 32-bit stream word.
package pim_wload_pkg;

   localparam int BEATS_DEF = 16;
   localparam int CNT_W_DEF = 4;

   localparam int CAM_MSB = 31;
   localparam int CAM_LSB = 16;
   localparam int CIM_MSB = 15;
   localparam int CIM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pim_wload_timer.sv
// Ack-wait timer: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT_CYC-th one.
module pim_wload_timer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         cnt <= '0;
      else if (i_en && !o_expire)
         cnt <= cnt + 1'b1;
   end

   assign o_expire = i_en && (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pim_weight_loader.sv
// Sequencer feeding the PIM weight buffer one row at a time and strobing the
// macro row write. Optional ack timeout: define PIM_WLOAD_ACK_TIMEOUT_EN.
module pim_weight_loader
   import pim_wload_pkg::*;
#(
   parameter int BEATS       = BEATS_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int ROW_W       = 6,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [ROW_W-1:0] i_row_base,
   input  logic [ROW_W:0]   i_num_rows,
   input  logic             i_data_valid,
   input  logic [31:0]      i_data,
   output logic             o_data_ready,
   output logic             o_weight_in_en,
   output logic [CNT_W-1:0] o_counter,
   output logic [31:0]      o_wdata,
   output logic             o_weight_out_en,
   output logic             o_macro_we,
   output logic [ROW_W-1:0] o_macro_row,
   input  logic             i_macro_ack,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   beat, cnt_q;
   logic [31:0]        wdata_q;
   logic [ROW_W-1:0]   row;
   logic [ROW_W:0]     rows_left;
   logic               hs, last_beat, start_ok, expire, err;

   assign hs        = (state == ST_FILL) && i_data_valid;
   assign last_beat = (beat == CNT_W'(BEATS - 1));
   assign start_ok  = (state == ST_IDLE) && i_start;

`ifdef PIM_WLOAD_ACK_TIMEOUT_EN
   pim_wload_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (state != ST_WRITE),
      .i_en     ((state == ST_WRITE) && !i_macro_ack),
      .o_expire (expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || start_ok)
         err <= 1'b0;
      else if (expire)
         err <= 1'b1;
   end
`else
   // No ack timeout in this build: WRITE waits for ack forever.
   assign expire = (TIMEOUT_CYC < 0);
   assign err    = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (i_start) state_nx = (i_num_rows == '0) ? ST_DONE : ST_FILL;
         ST_FILL:  if (hs && last_beat) state_nx = ST_WRITE;
         ST_WRITE: begin
            if (i_macro_ack)
               state_nx = (rows_left == (ROW_W+1)'(1)) ? ST_DONE : ST_FILL;
            else if (expire)
               state_nx = ST_DONE;
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Beat index wraps naturally since BEATS == 2**CNT_W; row wraps mod 2**ROW_W.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         beat      <= '0;
         row       <= '0;
         rows_left <= '0;
         cnt_q     <= '0;
         wdata_q   <= '0;
      end else begin
         if (start_ok) begin
            row       <= i_row_base;
            rows_left <= i_num_rows;
            beat      <= '0;
         end
         if (hs) begin
            beat    <= beat + 1'b1;
            cnt_q   <= beat;
            wdata_q <= i_data;
         end
         if ((state == ST_WRITE) && i_macro_ack && (rows_left != (ROW_W+1)'(1))) begin
            row       <= row + 1'b1;
            rows_left <= rows_left - 1'b1;
         end
      end
   end

   // Beat 0 lands in the buffer's MSB slice; the buffer decodes o_counter.
   always_comb begin
      o_data_ready    = 1'b0;
      o_weight_in_en  = 1'b0;
      o_counter       = cnt_q;
      o_wdata         = wdata_q;
      o_weight_out_en = 1'b0;
      o_macro_we      = 1'b0;
      o_macro_row     = '0;
      o_done          = 1'b0;
      case (state)
         ST_FILL: begin
            o_data_ready = 1'b1;
            if (i_data_valid) begin
               o_weight_in_en = 1'b1;
               o_counter      = beat;
               o_wdata        = {i_data[CAM_MSB:CAM_LSB], i_data[CIM_MSB:CIM_LSB]};
            end
         end
         ST_WRITE: begin
            o_weight_out_en = 1'b1;
            o_macro_we      = 1'b1;
            o_macro_row     = row;
         end
         ST_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   assign o_busy = (state != ST_IDLE);
   assign o_err  = err;

endmodule
